light_dance_seq: RTL and testbench
==================================

LIGHT_DANCE_SEQ -- requirements
Module: light_dance_seq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL be the number of LED flops driven; legal range 2..32.
REQ-002 Parameter DIV_W, default 4, SHALL be the width of the step-period field.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 arst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 start  input  1  SHALL be a level-sampled request to begin a dance, honoured only in IDLE.
REQ-006 stop  input  1  SHALL be a level-sampled request to end a dance, honoured only in RUN.
REQ-007 mode  input  2  SHALL select the pattern: 00 rotate-left, 01 rotate-right, 10 bounce, 11 blink.
REQ-008 period  input  DIV_W  SHALL set clk cycles between steps minus one.
REQ-009 load  output  WIDTH  SHALL carry one load-enable per downstream data flop.
REQ-010 din  output  WIDTH  SHALL carry one data bit per downstream data flop.
REQ-011 running  output  1  SHALL be high while in RUN.
REQ-012 step  output  1  SHALL pulse for one cycle whenever load is non-zero.

Function
REQ-013 States SHALL be IDLE, RUN, CLEAR.
REQ-014 IDLE with start=1 SHALL go to RUN and, in the following cycle, drive load=all ones, din=seed (seed = 1 at bit 0 for modes 00/01/10, all ones for 11).
REQ-015 An internal pattern register pat SHALL mirror the downstream flop contents at all times.
REQ-016 In RUN a tick counter SHALL count 0..period; the cycle it equals period it SHALL reset to 0 and produce a step.
REQ-017 On each step the next pattern SHALL be: 00 rotate pat left by 1 (MSB to bit 0); 01 rotate right by 1; 10 shift single lit bit in current direction, reversing direction on reaching bit WIDTH-1 or bit 0; 11 bitwise invert.
REQ-018 On each step load SHALL equal pat XOR next and din SHALL equal next; pat SHALL take next in the same edge.
REQ-019 load, din, step SHALL be registered, valid exactly one cycle, and zero in every other cycle.
REQ-020 period=0 SHALL produce a step every cycle; period=P SHALL produce steps every P+1 cycles.
REQ-021 mode SHALL be sampled only at a step; a change of mode SHALL reseed pat as in REQ-014 (load=all ones) instead of advancing, and reset bounce direction to left.
REQ-022 RUN with stop=1 SHALL go to CLEAR and drive load=all ones, din=0 for one cycle, then return to IDLE with pat=0.
REQ-023 start and stop high together SHALL be treated as stop in RUN and as no-op in IDLE.
REQ-024 A stop coinciding with a step SHALL take priority; the step SHALL be discarded.
REQ-025 Bounce direction SHALL begin leftward after every seed.

Reset
REQ-026 arst=1 SHALL immediately force state=IDLE, counter=0, pat=0, direction=left, load=0, din=0, step=0, running=0.
REQ-027 arst asserted mid-dance SHALL discard all pending steps; no load pulse SHALL follow reset release until a new start.

Structure
REQ-028 A shared package light_dance_pkg SHALL hold the state enumeration and the four mode code constants.
REQ-029 The tick counter SHALL be a separate sub-module tick_divider (clk, arst, enable, period, tick).
REQ-030 light_dance_seq SHALL drive WIDTH instances of the existing single-bit load-enabled flop, one per load/din bit pair.

Verification
REQ-031 WIDTH=8, mode=00, period=0, start -> seed 0x01 then flop bank 0x02,0x04,...,0x80,0x01 on consecutive cycles.
REQ-032 mode=10, period=2 -> lit bit 0,1..7,6..0 with a step every 3 cycles; load has exactly two bits set per step.
REQ-033 mode=11, period=1 -> bank alternates 0xFF/0x00 every 2 cycles, load=0xFF each step.
REQ-034 stop and start high on the same cycle as a step in RUN -> CLEAR, load=0xFF, din=0x00 once, then IDLE, running=0.
REQ-035 arst pulsed mid-RUN -> all outputs 0 immediately, no load pulse for 20 cycles after release without start.
REQ-036 mode changed 01->10 mid-run -> next step reseeds 0x01 with load=0xFF, then bounce proceeds leftward.

Source files
------------

// File: rtl/light_dance_pkg.sv
// light_dance_pkg: shared state enumeration and pattern mode codes for the light dance sequencer.
package light_dance_pkg;
    typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;
    localparam logic [1:0] MODE_ROL    = 2'b00;
    localparam logic [1:0] MODE_ROR    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;
endpackage

// File: rtl/ld_flop.sv
// ld_flop: single-bit data flop with load enable, one per downstream LED.
module ld_flop (
    input  logic clk,
    input  logic arst,
    input  logic en,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or posedge arst)
        if (arst) q <= 1'b0;
        else if (en) q <= d;
endmodule

// File: rtl/tick_divider.sv
// tick_divider: counts 0..period while enabled and flags the terminal count.
module tick_divider #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             enable,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    assign tick = enable && (cnt == period);
    always_ff @(posedge clk or posedge arst)
        if (arst) cnt <= '0;
        else if (!enable || tick) cnt <= '0;
        else cnt <= cnt + 1'b1;
endmodule

// File: rtl/light_dance_seq.sv
// light_dance_seq: steps an LED pattern through a bank of load-enabled flops,
// emitting only the bits that change on each step.
module light_dance_seq
    import light_dance_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] period,
    output logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] bank,
    output logic             running,
    output logic             step
);
    state_t           state;
    logic [WIDTH-1:0] pat, next, seed;
    logic [1:0]       cur_mode;
    logic             dir_right, next_dir, tick;

    tick_divider #(.DIV_W(DIV_W)) u_div (
        .clk(clk), .arst(arst), .enable(state == RUN), .period(period), .tick(tick)
    );

    always_comb begin
        seed     = (mode == MODE_BLINK) ? '1 : WIDTH'(1);
        // bounce reverses when the lit bit sits at the end it is heading toward
        next_dir = dir_right ? !pat[0] : pat[WIDTH-1];
        next     = (cur_mode == MODE_ROL) ? {pat[WIDTH-2:0], pat[WIDTH-1]} :
                   (cur_mode == MODE_ROR) ? {pat[0], pat[WIDTH-1:1]} :
                   (cur_mode == MODE_BOUNCE) ? (next_dir ? pat >> 1 : pat << 1) : ~pat;
    end

    always_ff @(posedge clk or posedge arst)
        if (arst) begin
            state     <= IDLE;
            pat       <= '0;
            dir_right <= 1'b0;
            cur_mode  <= MODE_ROL;
            load      <= '0;
            din       <= '0;
            step      <= 1'b0;
            running   <= 1'b0;
        end else begin
            load <= '0;
            din  <= '0;
            step <= 1'b0;
            case (state)
                IDLE: if (start && !stop) begin
                    state     <= RUN;
                    running   <= 1'b1;
                    pat       <= seed;
                    cur_mode  <= mode;
                    dir_right <= 1'b0;
                    load      <= '1;
                    din       <= seed;
                    step      <= 1'b1;
                end
                RUN: if (stop) begin
                    state   <= CLEAR;
                    running <= 1'b0;
                    pat     <= '0;
                    load    <= '1;
                    step    <= 1'b1;
                end else if (tick) begin
                    step <= 1'b1;
                    if (mode != cur_mode) begin
                        cur_mode  <= mode;
                        pat       <= seed;
                        dir_right <= 1'b0;
                        load      <= '1;
                        din       <= seed;
                    end else begin
                        pat       <= next;
                        dir_right <= next_dir;
                        load      <= pat ^ next;
                        din       <= next;
                    end
                end
                default: state <= IDLE;
            endcase
        end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bank
        ld_flop u_flop (.clk(clk), .arst(arst), .en(load[g]), .d(din[g]), .q(bank[g]));
    end
endmodule

// File: tb/tb_light_dance_seq.sv
// tb_light_dance_seq: directed literal checks plus randomized run against a pattern-by-step-index model.
module tb_light_dance_seq;
    logic       clk = 1'b0, arst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] period = 4'd0;
    logic [7:0] load, din, bank;
    logic       running, step;
    int checks = 0, errors = 0;

    light_dance_seq #(.WIDTH(8), .DIV_W(4)) dut (
        .clk(clk), .arst(arst), .start(start), .stop(stop), .mode(mode), .period(period),
        .load(load), .din(din), .bank(bank), .running(running), .step(step)
    );

    always #5 clk = ~clk;

    // Pattern after k steps since the last seed, straight from the mode definitions.
    function automatic logic [7:0] pat_of(input logic [1:0] md, input int k);
        int p;
        case (md)
            2'd0: return 8'h01 << (k % 8);
            2'd1: return 8'h01 << ((8 - k % 8) % 8);
            2'd2: begin
                p = k % 14;
                return 8'h01 << ((p < 8) ? p : 14 - p);
            end
            default: return (k % 2 == 1) ? 8'h00 : 8'hFF;
        endcase
    endfunction

    bit         m_run = 0, m_clr = 0;
    logic [1:0] m_mode = 0;
    int         m_k = 0, m_cnt = 0, m_per = 0;
    logic [7:0] m_bank = 0, e_load = 0, e_din = 0;
    logic       e_step = 0, e_run = 0;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_run = 0; m_clr = 0; m_bank = 0;
            e_load = 0; e_din = 0; e_step = 0; e_run = 0;
        end else begin
            m_bank = (m_bank & ~e_load) | (e_din & e_load);
            e_load = 0; e_din = 0; e_step = 0;
            if (m_clr) m_clr = 0;
            else if (!m_run) begin
                if (start && !stop) begin
                    m_run = 1; m_mode = mode; m_per = int'(period); m_k = 0; m_cnt = 0;
                    e_load = 8'hFF; e_din = pat_of(mode, 0); e_step = 1;
                end
            end else if (stop) begin
                m_run = 0; m_clr = 1; e_load = 8'hFF; e_din = 8'h00; e_step = 1;
            end else begin
                m_cnt++;
                if (m_cnt == m_per + 1) begin
                    m_cnt = 0; e_step = 1;
                    if (mode != m_mode) begin
                        m_mode = mode; m_k = 0; e_load = 8'hFF; e_din = pat_of(mode, 0);
                    end else begin
                        e_din = pat_of(m_mode, m_k + 1);
                        e_load = pat_of(m_mode, m_k) ^ e_din;
                        m_k++;
                    end
                end
            end
            e_run = m_run;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_load", 32'(load), 32'(e_load));
        chk("model_din", 32'(din), 32'(e_din));
        chk("model_step", 32'(step), 32'(e_step));
        chk("model_running", 32'(running), 32'(e_run));
        chk("model_bank", 32'(bank), 32'(m_bank));
    end

    task automatic tk();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rol_exp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        int         bpos [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
        int         pulses;
        tk();
        chk("rst_load", 32'(load), 0);
        chk("rst_din", 32'(din), 0);
        chk("rst_step", 32'(step), 0);
        chk("rst_running", 32'(running), 0);
        arst = 1'b0;
        // rotate-left, step every cycle
        tk(); mode = 2'd0; period = 4'd0; start = 1'b1;
        tk(); start = 1'b0;
        chk("rol_seed_din", 32'(din), 32'h01);
        chk("rol_seed_load", 32'(load), 32'hFF);
        chk("rol_running", 32'(running), 1);
        for (int i = 0; i < 8; i++) begin
            tk();
            chk("rol_din", 32'(din), 32'(rol_exp[i]));
            if (i == 0) chk("rol_bank", 32'(bank), 32'h01);
        end
        stop = 1'b1;
        tk(); stop = 1'b0;
        chk("clr_load", 32'(load), 32'hFF);
        chk("clr_din", 32'(din), 32'h00);
        tk();
        chk("idle_load", 32'(load), 0);
        // bounce, step every 3 cycles, then stop+start on a step
        tk(); mode = 2'd2; period = 4'd2; start = 1'b1;
        tk(); start = 1'b0;
        chk("bnc_seed", 32'(din), 32'h01);
        for (int i = 0; i < 15; i++) begin
            repeat (3) tk();
            chk("bnc_din", 32'(din), 32'h01 << bpos[i]);
            chk("bnc_load_bits", 32'($countones(load)), 2);
        end
        tk(); tk(); start = 1'b1; stop = 1'b1;
        tk(); start = 1'b0; stop = 1'b0;
        chk("ss_load", 32'(load), 32'hFF);
        chk("ss_din", 32'(din), 32'h00);
        chk("ss_running", 32'(running), 0);
        tk();
        chk("ss_idle_load", 32'(load), 0);
        chk("ss_idle_running", 32'(running), 0);
        // blink, step every 2 cycles
        tk(); mode = 2'd3; period = 4'd1; start = 1'b1;
        tk(); start = 1'b0;
        chk("blk_seed", 32'(din), 32'hFF);
        tk();
        chk("blk_gap_step", 32'(step), 0);
        tk();
        chk("blk_off_din", 32'(din), 32'h00);
        chk("blk_off_load", 32'(load), 32'hFF);
        tk(); tk();
        chk("blk_on_din", 32'(din), 32'hFF);
        stop = 1'b1;
        tk(); stop = 1'b0;
        tk();
        // rotate-right then switch to bounce mid-run
        tk(); mode = 2'd1; period = 4'd0; start = 1'b1;
        tk(); start = 1'b0;
        chk("ror_seed", 32'(din), 32'h01);
        tk();
        chk("ror_din", 32'(din), 32'h80);
        chk("ror_load", 32'(load), 32'h81);
        mode = 2'd2;
        tk();
        chk("reseed_din", 32'(din), 32'h01);
        chk("reseed_load", 32'(load), 32'hFF);
        tk();
        chk("reseed_next_din", 32'(din), 32'h02);
        chk("reseed_next_load", 32'(load), 32'h03);
        stop = 1'b1;
        tk(); stop = 1'b0;
        tk();
        // async reset mid-run
        tk(); mode = 2'd0; period = 4'd3; start = 1'b1;
        tk(); start = 1'b0;
        repeat (6) tk();
        #2 arst = 1'b1;
        #1;
        chk("arst_load", 32'(load), 0);
        chk("arst_din", 32'(din), 0);
        chk("arst_step", 32'(step), 0);
        chk("arst_running", 32'(running), 0);
        chk("arst_bank", 32'(bank), 0);
        tk(); arst = 1'b0;
        pulses = 0;
        repeat (20) begin
            tk();
            if (load != 8'h00) pulses++;
        end
        chk("no_load_after_rst", pulses, 0);
        // randomized traffic
        repeat (4000) begin
            tk();
            if (!m_run) period = 4'($urandom_range(0, 3));
            start = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                #2 arst = 1'b1;
                #2 arst = 1'b0;
            end
        end
        tk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
